// File: rtl/triangle_fetch_if.sv
// rtl/triangle_fetch_if.sv - vertex beat stream between triangle_fetch and the vertex transform stage
interface triangle_fetch_if;
  logic        vertex_valid_out;
  logic        vertex_ready_in;
  logic [95:0] position_out;
  logic [95:0] normal_out;
  logic [1:0]  vertex_idx_out;
  logic        tri_last_out;

  modport master (
    output vertex_valid_out,
    output position_out,
    output normal_out,
    output vertex_idx_out,
    output tri_last_out,
    input  vertex_ready_in
  );

  modport slave (
    input  vertex_valid_out,
    input  position_out,
    input  normal_out,
    input  vertex_idx_out,
    input  tri_last_out,
    output vertex_ready_in
  );
endinterface

// File: rtl/triangle_fetch.sv
// rtl/triangle_fetch.sv - walks triangles, fetches index/position/normal ROMs, emits vertex beats (option: FETCH_SKIP_DEGENERATE_EN)
module triangle_fetch #(
  parameter int MEM_LATENCY = 2,
  parameter int ID_WIDTH    = 12
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ID_WIDTH-1:0]   triangle_count_in,
  output logic [ID_WIDTH-1:0]   index_id_out,
  input  logic [3*ID_WIDTH-1:0] index_in,
  output logic [ID_WIDTH-1:0]   position_id_out,
  input  logic [95:0]           position_in,
  output logic [ID_WIDTH-1:0]   normal_id_out,
  input  logic [95:0]           normal_in,
  triangle_fetch_if.master      vtx,
  output logic                  busy_out,
  output logic                  done_out
);

`ifdef FETCH_SKIP_DEGENERATE_EN
  localparam bit SKIP_DEGEN = 1'b1;
`else
  localparam bit SKIP_DEGEN = 1'b0;
`endif

  localparam int WAIT_W = $clog2(MEM_LATENCY + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX_WAIT,
    S_VTX_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ID_WIDTH-1:0]   count_q;
  logic [ID_WIDTH-1:0]   tri_q;
  logic [ID_WIDTH-1:0]   index_id_q;
  logic [ID_WIDTH-1:0]   vtx_id_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [1:0]            corner_q;
  logic [ID_WIDTH-1:0]   v0_q, v1_q, v2_q;
  logic [95:0]           position_q;
  logic [95:0]           normal_q;
  logic                  valid_q;
  logic [1:0]            vidx_q;
  logic                  tri_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  wait_done_d;
  logic                  last_tri_d;
  logic                  degenerate_d;
  logic [ID_WIDTH-1:0]   in_v0_d, in_v1_d, in_v2_d;
  logic [ID_WIDTH-1:0]   next_vtx_id_d;

  // Wait expiry, last-triangle test and degenerate detection on the raw index word
  always_comb begin
    in_v0_d      = index_in[ID_WIDTH-1:0];
    in_v1_d      = index_in[2*ID_WIDTH-1:ID_WIDTH];
    in_v2_d      = index_in[3*ID_WIDTH-1:2*ID_WIDTH];
    wait_done_d  = (wait_q == WAIT_W'(MEM_LATENCY));
    last_tri_d   = (tri_q == (count_q - ID_WIDTH'(1)));
    degenerate_d = (in_v0_d == in_v1_d) || (in_v1_d == in_v2_d) || (in_v0_d == in_v2_d);
    next_vtx_id_d = (corner_q == 2'd0) ? v1_q : v2_q;
  end

  // Pass sequencer: all outputs registered, addresses only move on state entry
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      tri_q      <= '0;
      index_id_q <= '0;
      vtx_id_q   <= '0;
      wait_q     <= '0;
      corner_q   <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      position_q <= '0;
      normal_q   <= '0;
      valid_q    <= 1'b0;
      vidx_q     <= '0;
      tri_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            count_q <= triangle_count_in;
            tri_q   <= '0;
            wait_q  <= '0;
            if (triangle_count_in == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_IDX_WAIT;
              index_id_q <= '0;
              busy_q     <= 1'b1;
            end
          end
        end

        S_IDX_WAIT: begin
          if (wait_done_d) begin
            wait_q   <= '0;
            corner_q <= '0;
            v0_q     <= in_v0_d;
            v1_q     <= in_v1_d;
            v2_q     <= in_v2_d;
            if (SKIP_DEGEN && degenerate_d) begin
              if (last_tri_d) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                tri_q      <= tri_q + ID_WIDTH'(1);
                index_id_q <= tri_q + ID_WIDTH'(1);
              end
            end else begin
              state_q  <= S_VTX_WAIT;
              vtx_id_q <= in_v0_d;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        S_VTX_WAIT: begin
          if (wait_done_d) begin
            wait_q     <= '0;
            position_q <= position_in;
            normal_q   <= normal_in;
            valid_q    <= 1'b1;
            vidx_q     <= corner_q;
            tri_last_q <= (corner_q == 2'd2);
            state_q    <= S_EMIT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        S_EMIT: begin
          if (vtx.vertex_ready_in) begin
            valid_q    <= 1'b0;
            tri_last_q <= 1'b0;
            if (corner_q != 2'd2) begin
              corner_q <= corner_q + 2'd1;
              vtx_id_q <= next_vtx_id_d;
              state_q  <= S_VTX_WAIT;
            end else if (last_tri_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              tri_q      <= tri_q + ID_WIDTH'(1);
              index_id_q <= tri_q + ID_WIDTH'(1);
              state_q    <= S_IDX_WAIT;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign index_id_out         = index_id_q;
  assign position_id_out      = vtx_id_q;
  assign normal_id_out        = vtx_id_q;
  assign busy_out             = busy_q;
  assign done_out             = done_q;
  assign vtx.vertex_valid_out = valid_q;
  assign vtx.position_out     = position_q;
  assign vtx.normal_out       = normal_q;
  assign vtx.vertex_idx_out   = vidx_q;
  assign vtx.tri_last_out     = tri_last_q;

endmodule

// File: tb/tb_triangle_fetch.sv
// tb/tb_triangle_fetch.sv - randomized self-checking bench for triangle_fetch
module tb_triangle_fetch;
  localparam int ML  = 2;
  localparam int IDW = 12;
`ifdef FETCH_SKIP_DEGENERATE_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [95:0] pos;
    logic [95:0] nrm;
    logic [11:0] vid;
    logic [1:0]  vidx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] tcount = '0;
  logic [11:0] index_id, position_id, normal_id;
  logic [35:0] index_in;
  logic [95:0] position_in, normal_in;
  logic        busy, done;

  triangle_fetch_if vif ();

  triangle_fetch #(.MEM_LATENCY(ML), .ID_WIDTH(IDW)) dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .start_in          (start),
    .triangle_count_in (tcount),
    .index_id_out      (index_id),
    .index_in          (index_in),
    .position_id_out   (position_id),
    .position_in       (position_in),
    .normal_id_out     (normal_id),
    .normal_in         (normal_in),
    .vtx               (vif),
    .busy_out          (busy),
    .done_out          (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ROM contents
  logic [35:0] idx_mem [0:4095];
  logic [31:0] salt;

  function automatic logic [95:0] pos_f(input logic [11:0] id);
    logic [31:0] x;
    x = {20'h0, id};
    return {(x * 32'd3) ^ salt, x + salt, ~x ^ {salt[15:0], salt[31:16]}};
  endfunction

  function automatic logic [95:0] nrm_f(input logic [11:0] id);
    logic [31:0] x;
    x = {20'h0, id};
    return {x ^ 32'hA5A5_0000, (x * 32'd5) + salt, salt - x};
  endfunction

  // ROMs with MEM_LATENCY-stage output pipeline
  logic [35:0] idx_p1, idx_p2;
  logic [95:0] pos_p1, pos_p2, nrm_p1, nrm_p2;
  always @(posedge clk) begin
    idx_p1 <= idx_mem[index_id];
    idx_p2 <= idx_p1;
    pos_p1 <= pos_f(position_id);
    pos_p2 <= pos_p1;
    nrm_p1 <= nrm_f(normal_id);
    nrm_p2 <= nrm_p1;
  end
  assign index_in    = idx_p2;
  assign position_in = pos_p2;
  assign normal_in   = nrm_p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge
  beat_t cur_beat;
  assign cur_beat = {vif.position_out, vif.normal_out, position_id, vif.vertex_idx_out, vif.tri_last_out};

  beat_t       got_arr [0:1023];
  int          got_cyc [0:1023];
  int          got_n = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done_busy_err = 0;
  int          stab_err = 0;
  int          id_err = 0;
  int          addr_chg = 0;
  int          valid_seen = 0;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat;
  logic [11:0] prev_idx_id = '0;
  logic [11:0] prev_pos_id = '0;

  always @(negedge clk) begin
    if (vif.vertex_valid_out && vif.vertex_ready_in) begin
      got_arr[got_n % 1024] <= cur_beat;
      got_cyc[got_n % 1024] <= cyc;
      got_n <= got_n + 1;
    end
    if (prev_stall && (!vif.vertex_valid_out || cur_beat != prev_beat)) stab_err <= stab_err + 1;
    prev_stall <= vif.vertex_valid_out && !vif.vertex_ready_in;
    prev_beat  <= cur_beat;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (busy) done_busy_err <= done_busy_err + 1;
    end
    if (position_id != normal_id) id_err <= id_err + 1;
    if (index_id != prev_idx_id || position_id != prev_pos_id) addr_chg <= addr_chg + 1;
    prev_idx_id <= index_id;
    prev_pos_id <= position_id;
    if (vif.vertex_valid_out) valid_seen <= valid_seen + 1;
  end

  // Reference model: the beats a pass over triangles 0..cnt-1 must produce
  beat_t exp_arr [0:1023];
  int    exp_n;

  task automatic build_expected(input int cnt);
    logic [11:0] v [3];
    beat_t b;
    exp_n = 0;
    for (int t = 0; t < cnt; t++) begin
      v[0] = idx_mem[t][11:0];
      v[1] = idx_mem[t][23:12];
      v[2] = idx_mem[t][35:24];
      if (SKIP_EN && (v[0] == v[1] || v[1] == v[2] || v[0] == v[2])) continue;
      for (int c = 0; c < 3; c++) begin
        b.pos  = pos_f(v[c]);
        b.nrm  = nrm_f(v[c]);
        b.vid  = v[c];
        b.vidx = 2'(c);
        b.last = (c == 2);
        exp_arr[exp_n] = b;
        exp_n++;
      end
    end
  endtask

  task automatic fill_idx(input int cnt, input int pct);
    logic [11:0] a, b, c;
    for (int t = 0; t < cnt; t++) begin
      a = 12'($urandom);
      b = a + 12'($urandom_range(1, 100));
      c = b + 12'($urandom_range(1, 100));
      if ($urandom_range(0, 99) < pct) begin
        case ($urandom_range(0, 2))
          0:       b = a;
          1:       c = b;
          default: c = a;
        endcase
      end
      idx_mem[t] = {c, b, a};
    end
  endtask

  // Pass driver
  int base_got, base_done, base_stab, base_addr, base_valid, pass_start_cyc;
  bit timed_out;

  task automatic do_pass(input int cnt, input int rmode, input bit mid_start);
    int budget, vcyc;
    base_got   = got_n;
    base_done  = done_cnt;
    base_stab  = stab_err;
    base_addr  = addr_chg;
    base_valid = valid_seen;
    @(posedge clk); #1;
    tcount = 12'(cnt);
    start  = 1'b1;
    pass_start_cyc = cyc;
    budget = 0;
    vcyc   = 0;
    while (done_cnt == base_done && budget < 4000) begin
      case (rmode)
        0: vif.vertex_ready_in = 1'b1;
        1: vif.vertex_ready_in = 1'($urandom_range(0, 1));
        default: begin
          if (vif.vertex_valid_out) begin
            vif.vertex_ready_in = (vcyc >= 5);
            vcyc = vif.vertex_ready_in ? 0 : vcyc + 1;
          end else begin
            vif.vertex_ready_in = 1'b0;
            vcyc = 0;
          end
        end
      endcase
      @(posedge clk); #1;
      budget++;
      start  = mid_start && (budget == 14);
      tcount = 12'($urandom);
    end
    timed_out = (done_cnt == base_done);
    start = 1'b0;
    vif.vertex_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    tcount = 12'd5;
    vif.vertex_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vif.vertex_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vif.vertex_valid_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if ({index_id, position_id, normal_id} !== 36'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", {index_id, position_id, normal_id}); end
    checks++; if ({vif.position_out, vif.normal_out, vif.vertex_idx_out, vif.tri_last_out} !== '0) begin failures++; $display("FAIL reset_payload got=%h exp=0", {vif.position_out, vif.normal_out}); end
    start = 1'b0;
    vif.vertex_ready_in = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int n, exp_c;
    idx_mem[0] = {12'd2, 12'd1, 12'd0};
    build_expected(1);
    do_pass(1, 0, 1'b0);
    n = got_n - base_got;
    checks++; if (timed_out) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
    checks++; if (n !== 3) begin failures++; $display("FAIL single_beats got=%0d exp=3", n); end
    for (int i = 0; i < n && i < exp_n; i++) begin
      checks++; if (got_arr[(base_got + i) % 1024] !== exp_arr[i]) begin failures++; $display("FAIL single_beat%0d got=%h exp=%h", i, got_arr[(base_got + i) % 1024], exp_arr[i]); end
      checks++; if (got_arr[(base_got + i) % 1024].vid !== 12'(i)) begin failures++; $display("FAIL single_pos_id%0d got=%0d exp=%0d", i, got_arr[(base_got + i) % 1024].vid, i); end
      exp_c = pass_start_cyc + 1 + 2 * (ML + 1) + i * (ML + 2);
      checks++; if (got_cyc[(base_got + i) % 1024] !== exp_c) begin failures++; $display("FAIL single_cycle%0d got=%0d exp=%0d", i, got_cyc[(base_got + i) % 1024], exp_c); end
    end
    if (n == 3) begin
      checks++; if (done_cyc !== got_cyc[(base_got + 2) % 1024] + 1) begin failures++; $display("FAIL single_done_cycle got=%0d exp=%0d", done_cyc, got_cyc[(base_got + 2) % 1024] + 1); end
    end
    checks++; if (done_cnt - base_done !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - base_done); end
    checks++; if (done_busy_err !== 0) begin failures++; $display("FAIL single_busy_at_done got=%0d exp=0", done_busy_err); end
  endtask

  task automatic test_stall();
    int n;
    fill_idx(2, 0);
    build_expected(2);
    do_pass(2, 2, 1'b0);
    n = got_n - base_got;
    checks++; if (timed_out) begin failures++; $display("FAIL stall_timeout got=no_done exp=done"); end
    checks++; if (n !== 6 || exp_n !== 6) begin failures++; $display("FAIL stall_beats got=%0d exp=6", n); end
    for (int i = 0; i < n && i < exp_n; i++) begin
      checks++; if (got_arr[(base_got + i) % 1024] !== exp_arr[i]) begin failures++; $display("FAIL stall_beat%0d got=%h exp=%h", i, got_arr[(base_got + i) % 1024], exp_arr[i]); end
    end
    checks++; if (stab_err - base_stab !== 0) begin failures++; $display("FAIL stall_stability got=%0d exp=0", stab_err - base_stab); end
    checks++; if (valid_seen - base_valid !== 36) begin failures++; $display("FAIL stall_valid_cycles got=%0d exp=36", valid_seen - base_valid); end
  endtask

  task automatic test_zero_count();
    do_pass(0, 0, 1'b0);
    checks++; if (timed_out) begin failures++; $display("FAIL zero_timeout got=no_done exp=done"); end
    checks++; if (done_cyc !== pass_start_cyc + 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, pass_start_cyc + 1); end
    checks++; if (done_cnt - base_done !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt - base_done); end
    checks++; if (addr_chg - base_addr !== 0) begin failures++; $display("FAIL zero_addr_change got=%0d exp=0", addr_chg - base_addr); end
    checks++; if (valid_seen - base_valid !== 0) begin failures++; $display("FAIL zero_valid got=%0d exp=0", valid_seen - base_valid); end
  endtask

  task automatic test_mid_start();
    int n;
    fill_idx(3, 0);
    build_expected(3);
    do_pass(3, 0, 1'b1);
    n = got_n - base_got;
    checks++; if (timed_out) begin failures++; $display("FAIL midstart_timeout got=no_done exp=done"); end
    checks++; if (n !== 9 || exp_n !== 9) begin failures++; $display("FAIL midstart_beats got=%0d exp=9", n); end
    for (int i = 0; i < n && i < exp_n; i++) begin
      checks++; if (got_arr[(base_got + i) % 1024] !== exp_arr[i]) begin failures++; $display("FAIL midstart_beat%0d got=%h exp=%h", i, got_arr[(base_got + i) % 1024], exp_arr[i]); end
    end
    repeat (60) @(posedge clk);
    #1;
    checks++; if (done_cnt - base_done !== 1) begin failures++; $display("FAIL midstart_done_count got=%0d exp=1", done_cnt - base_done); end
  endtask

  task automatic test_reset_mid_pass();
    int budget, n, bd;
    fill_idx(2, 0);
    base_got = got_n;
    bd = done_cnt;
    @(posedge clk); #1;
    tcount = 12'd2;
    start = 1'b1;
    vif.vertex_ready_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (got_n - base_got < 4 && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++; if (got_n - base_got !== 4) begin failures++; $display("FAIL rstmid_reach got=%0d exp=4", got_n - base_got); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({vif.vertex_valid_out, busy, done} !== 3'b000) begin failures++; $display("FAIL rstmid_flags got=%b exp=000", {vif.vertex_valid_out, busy, done}); end
    checks++; if ({index_id, position_id, normal_id} !== 36'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", {index_id, position_id, normal_id}); end
    checks++; if ({vif.position_out, vif.normal_out, vif.vertex_idx_out, vif.tri_last_out} !== '0) begin failures++; $display("FAIL rstmid_payload got=%h exp=0", {vif.position_out, vif.vertex_idx_out}); end
    vif.vertex_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_cnt !== bd || busy !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%0d/%b exp=%0d/0", done_cnt, busy, bd); end
    fill_idx(1, 0);
    build_expected(1);
    do_pass(1, 0, 1'b0);
    n = got_n - base_got;
    checks++; if (timed_out || n !== 3) begin failures++; $display("FAIL rstmid_restart_beats got=%0d exp=3", n); end
    for (int i = 0; i < n && i < exp_n; i++) begin
      checks++; if (got_arr[(base_got + i) % 1024] !== exp_arr[i]) begin failures++; $display("FAIL rstmid_restart_beat%0d got=%h exp=%h", i, got_arr[(base_got + i) % 1024], exp_arr[i]); end
    end
  endtask

  task automatic test_degenerate();
    int n, lit;
    fill_idx(1, 0);
    idx_mem[1] = {12'd5, 12'd5, 12'd7};
    build_expected(2);
    do_pass(2, 0, 1'b0);
    n = got_n - base_got;
    lit = SKIP_EN ? 3 : 6;
    checks++; if (timed_out) begin failures++; $display("FAIL degen_timeout got=no_done exp=done"); end
    checks++; if (n !== lit) begin failures++; $display("FAIL degen_beats got=%0d exp=%0d", n, lit); end
    for (int i = 0; i < n && i < exp_n; i++) begin
      checks++; if (got_arr[(base_got + i) % 1024] !== exp_arr[i]) begin failures++; $display("FAIL degen_beat%0d got=%h exp=%h", i, got_arr[(base_got + i) % 1024], exp_arr[i]); end
    end
  endtask

  task automatic test_random();
    int n, cnt, pct;
    for (int p = 0; p < 7; p++) begin
      cnt = (p == 6) ? 3 : $urandom_range(1, 5);
      pct = (p == 6) ? 100 : 30;
      fill_idx(cnt, pct);
      build_expected(cnt);
      do_pass(cnt, 1, 1'b0);
      n = got_n - base_got;
      checks++; if (timed_out) begin failures++; $display("FAIL rand%0d_timeout got=no_done exp=done", p); end
      checks++; if (n !== exp_n) begin failures++; $display("FAIL rand%0d_beats got=%0d exp=%0d", p, n, exp_n); end
      for (int i = 0; i < n && i < exp_n; i++) begin
        checks++; if (got_arr[(base_got + i) % 1024] !== exp_arr[i]) begin failures++; $display("FAIL rand%0d_beat%0d got=%h exp=%h", p, i, got_arr[(base_got + i) % 1024], exp_arr[i]); end
      end
      checks++; if (done_cnt - base_done !== 1) begin failures++; $display("FAIL rand%0d_done_count got=%0d exp=1", p, done_cnt - base_done); end
      checks++; if (stab_err - base_stab !== 0) begin failures++; $display("FAIL rand%0d_stability got=%0d exp=0", p, stab_err - base_stab); end
    end
    checks++; if (id_err !== 0) begin failures++; $display("FAIL normal_id_tracks_position_id got=%0d exp=0", id_err); end
    checks++; if (done_busy_err !== 0) begin failures++; $display("FAIL busy_at_done got=%0d exp=0", done_busy_err); end
  endtask

  initial begin
    salt = $urandom;
    vif.vertex_ready_in = 1'b0;
    for (int i = 0; i < 4096; i++) idx_mem[i] = '0;
    test_reset();
    test_zero_count();
    test_single();
    test_stall();
    test_mid_start();
    test_reset_mid_pass();
    test_degenerate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
